link_scheduler: RTL and testbench
=================================

# link_scheduler

Sequences the single UART link between the controller board and the simulated car. The block shares the one UART transmit path among three requesters: drive-state refresh, place-barrier and destroy-barrier. It assembles the 8-bit command frame and handshakes with the UART transmitter. It also latches the returned detector frame, with an optional link watchdog. It sits between the mode logic (manual / semi-auto outputs) and `uart_top`, and replaces direct wiring of the frame onto the UART.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 1_000_000: idle period in cycles (10 ms at 100 MHz) after which the current drive frame is resent unprompted.
- `TIMEOUT_CYCLES`, default 10_000_000: cycles without a received frame before the link is declared dead. Used only with the watchdog.

Ports:
- `sys_clk` in 1: system clock, 100 MHz, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `power` in 1: car powered. When 0, the transmitted nibble is forced to 4'b0000.
- `moving_state` in 4: current drive nibble from manual or semi-auto logic.
- `place_req` in 1: single-cycle pulse requesting barrier placement.
- `destroy_req` in 1: single-cycle pulse requesting barrier destruction.
- `tx_busy` in 1: high while the UART transmitter is shifting a byte.
- `tx_start` out 1: one-cycle strobe that launches `tx_data`.
- `tx_data` out 8: frame `{2'b10, destroy, place, drive[3:0]}`.
- `place_ack` out 1: one-cycle pulse when a frame carrying place=1 is launched.
- `destroy_ack` out 1: one-cycle pulse when a frame carrying destroy=1 is launched.
- `rx_valid` in 1: one-cycle strobe, received byte available.
- `rx_data` in 8: received byte. Bits [3:0] are `{back, right, left, front}`.
- `detector` out 4: latched `{back, right, left, front}`.
- `link_ok` out 1: high once a frame has been received and the link is not timed out.

## Operation
- Pending flags:
  - `place_pend` is set by `place_req`. `destroy_pend` is set by `destroy_req`.
  - Both flags are cleared in LOAD when copied into the frame.
  - A request pulse in the same cycle as the LOAD clear wins: the flag stays set for the next frame.
- Drive-change detect: `drive_eff = power ? moving_state : 0`. A change flag is set whenever `drive_eff` differs from the last transmitted nibble.
- Refresh counter:
  - Counts up in IDLE and resets on every launch.
  - Reaching `REFRESH_CYCLES-1` raises a refresh trigger.
- FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE -> LOAD when (destroy_pend | place_pend | change | refresh) and `tx_busy`=0.
  - LOAD: registers `tx_data`, clears the pending flags it captured, pulses the matching acks, and records the sent nibble. -> SEND.
  - SEND: `tx_start`=1 for exactly one cycle. -> WAIT.
  - WAIT: waits for `tx_busy` to go high, then low. -> IDLE.
- Both barrier flags set at once: both bits go in the same frame and both acks pulse.
- `power` falling: the next frame carries drive 0. Pending barrier requests are still sent.
- Receive: on `rx_valid`, `detector <= rx_data[3:0]` and `link_ok <= 1`.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=8'h80, acks=0.
  - `detector`=4'b0000, `link_ok`=0.
  - FSM=IDLE; flags, counters and last-sent nibble = 0.
- Latency:
  - A request sampled at edge k, with the link idle and not busy, gives LOAD after edge k+1.
  - `tx_start` is high in the cycle after edge k+2.
  - Acks are high in the cycle after edge k+1.
- Throughput: one frame per UART byte time plus 3 cycles.
- `tx_data` is stable from LOAD until the next LOAD.
- `rx_valid` to `detector` update: 1 cycle.
- Reset mid-frame returns the block to IDLE immediately and drops the frame. `tx_start` deasserts asynchronously.

## Configuration
- `LINK_WATCHDOG_EN` defined:
  - A counter is cleared on `rx_valid` and saturates at `TIMEOUT_CYCLES`.
  - On reaching the limit, `link_ok`<=0 and `detector`<=4'b1111 (all blocked, fail-safe for semi-auto).
  - A later `rx_valid` restores normal behaviour.
- Macro undefined: no counter, and `detector` holds its last value indefinitely. `link_ok` goes high on the first frame and stays high until reset.

## Structure
- Shared package `link_pkg`:
  - FSM state enum.
  - `FRAME_HDR` = 2'b10.
  - Frame bit-index constants: `DESTROY_BIT`=5, `PLACE_BIT`=4.
  - Detector index constants `DET_FRONT`..`DET_BACK`.
- One sub-module, `link_watchdog`: the timeout counter plus the `link_ok` register, instantiated only under `LINK_WATCHDOG_EN`.

## Test plan
- Reset release, `power`=1, `moving_state`=4'b0001 -> one `tx_start`, `tx_data`=8'h81; after that, no frame until `REFRESH_CYCLES` elapse.
- `place_req` and `destroy_req` in the same cycle while idle -> `tx_data`=8'hB0 (drive 0), both acks pulse once, `tx_start` 2 cycles after the request edge.
- `place_req` while WAIT (`tx_busy`=1) -> no new `tx_start` until `tx_busy` falls; the next frame has bit4=1 and `place_ack` pulses.
- `power` falls with `moving_state`=4'b0010 -> next frame 8'h80.
- `rx_valid` with `rx_data`=8'h05 -> `detector`=4'b0101, `link_ok`=1. With `LINK_WATCHDOG_EN` and a small `TIMEOUT_CYCLES` and no further rx -> `detector`=4'b1111, `link_ok`=0.
- `rst` asserted in SEND -> `tx_start`=0 immediately. After release, `tx_data`=8'h80 and FSM is in IDLE.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and constants for the controller-to-car UART link scheduler.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } link_state_t;

    localparam logic [1:0] FRAME_HDR   = 2'b10;
    localparam int         DESTROY_BIT = 5;
    localparam int         PLACE_BIT   = 4;

    localparam int DET_FRONT = 0;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 2;
    localparam int DET_BACK  = 3;

    localparam logic [7:0] IDLE_FRAME = {FRAME_HDR, 6'b000000};

    function automatic logic [7:0] build_frame(input logic destroy, input logic place,
                                               input logic [3:0] drive);
        logic [7:0] frame;
        frame              = IDLE_FRAME;
        frame[DESTROY_BIT] = destroy;
        frame[PLACE_BIT]   = place;
        frame[3:0]         = drive;
        return frame;
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Receive-link timeout counter and link_ok register; used only when LINK_WATCHDOG_EN is defined.
module link_watchdog
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic rx_valid,
    output logic link_ok,
    output logic expire
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT_M1 = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    // Single-cycle strobe on the edge where the silence counter reaches its limit.
    assign expire = (cnt == LIMIT_M1) && !rx_valid;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            link_ok <= 1'b0;
        end else if (rx_valid) begin
            cnt     <= '0;
            link_ok <= 1'b1;
        end else begin
            if (cnt != LIMIT) begin
                cnt <= cnt + TW'(1);
            end
            if (expire) begin
                link_ok <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/link_scheduler.sv
// Shares the UART transmit path among drive refresh, place-barrier and destroy-barrier frames,
// and latches the returned detector frame. Define LINK_WATCHDOG_EN to add the receive timeout.
module link_scheduler
    import link_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [3:0] moving_state,
    input  logic       place_req,
    input  logic       destroy_req,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       place_ack,
    output logic       destroy_ack,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [3:0] detector,
    output logic       link_ok
);

    localparam int            RW          = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES - 1);

    link_state_t   state;
    logic          place_pend;
    logic          destroy_pend;
    logic [3:0]    last_nibble;
    logic [RW-1:0] refresh_cnt;
    logic          busy_seen;

    logic [3:0] drive_eff;
    logic       change;
    logic       refresh;
    logic       launch;
    logic [3:0] rx_det;

    assign drive_eff = power ? moving_state : 4'b0000;
    assign change    = (drive_eff != last_nibble);
    assign refresh   = (refresh_cnt == REFRESH_MAX);
    assign launch    = (state == IDLE) && !tx_busy &&
                       (destroy_pend || place_pend || change || refresh);

    assign rx_det = {rx_data[DET_BACK], rx_data[DET_RIGHT], rx_data[DET_LEFT], rx_data[DET_FRONT]};

    // A request arriving on the capture edge overwrites the clear, so it rides the next frame.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= IDLE_FRAME;
            place_ack    <= 1'b0;
            destroy_ack  <= 1'b0;
            place_pend   <= 1'b0;
            destroy_pend <= 1'b0;
            last_nibble  <= 4'b0000;
            refresh_cnt  <= '0;
            busy_seen    <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            place_ack   <= 1'b0;
            destroy_ack <= 1'b0;
            if (place_req) begin
                place_pend <= 1'b1;
            end
            if (destroy_req) begin
                destroy_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        state        <= LOAD;
                        tx_data      <= build_frame(destroy_pend, place_pend, drive_eff);
                        place_ack    <= place_pend;
                        destroy_ack  <= destroy_pend;
                        place_pend   <= place_req;
                        destroy_pend <= destroy_req;
                        last_nibble  <= drive_eff;
                        refresh_cnt  <= '0;
                    end else if (!refresh) begin
                        refresh_cnt <= refresh_cnt + RW'(1);
                    end
                end
                LOAD: begin
                    state    <= SEND;
                    tx_start <= 1'b1;
                end
                SEND: begin
                    state     <= WAIT;
                    busy_seen <= 1'b0;
                end
                WAIT: begin
                    // The transmitter must be seen busy before its idle means the byte is done.
                    if (!busy_seen) begin
                        if (tx_busy) begin
                            busy_seen <= 1'b1;
                        end
                    end else if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINK_WATCHDOG_EN
    logic expire;
    logic unused_bits;

    assign unused_bits = ^rx_data[7:4];

    link_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk (sys_clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .link_ok (link_ok),
        .expire  (expire)
    );

    // A dead link reports every direction blocked so semi-auto driving stops safely.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            detector <= 4'b0000;
        end else if (rx_valid) begin
            detector <= rx_det;
        end else if (expire) begin
            detector <= 4'b1111;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{rx_data[7:4], (TIMEOUT_CYCLES > 0)};

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            detector <= 4'b0000;
            link_ok  <= 1'b0;
        end else if (rx_valid) begin
            detector <= rx_det;
            link_ok  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_link_scheduler.sv
// Directed scoreboard bench for link_scheduler with a simple UART transmitter model.
module tb_link_scheduler;
    import link_pkg::*;

    localparam int REFRESH    = 300;
    localparam int TIMEOUT    = 50;
    localparam int BYTE_CYCLES = 10;

    logic       sys_clk;
    logic       rst;
    logic       power;
    logic [3:0] moving_state;
    logic       place_req;
    logic       destroy_req;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       place_ack;
    logic       destroy_ack;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] detector;
    logic       link_ok;

    int n_compared   = 0;
    int n_mismatched = 0;
    int frames       = 0;
    int place_acks   = 0;
    int destroy_acks = 0;
    logic [7:0] exp_q[$];

    link_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .power       (power),
        .moving_state(moving_state),
        .place_req   (place_req),
        .destroy_req (destroy_req),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .place_ack   (place_ack),
        .destroy_ack (destroy_ack),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .detector    (detector),
        .link_ok     (link_ok)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic place, input logic destroy);
        place_req   = place;
        destroy_req = destroy;
        @(posedge sys_clk);
        #1;
        place_req   = 1'b0;
        destroy_req = 1'b0;
    endtask

    task automatic waitFrames(input int target);
        int i = 0;
        while (frames < target && i < 200) begin
            @(negedge sys_clk);
            i++;
        end
        checkOutput("frame_count", frames, target);
    endtask

    task automatic settle();
        repeat (BYTE_CYCLES + 10) @(negedge sys_clk);
    endtask

    // UART transmitter model: busy for one byte time after each launch.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge sys_clk);
            if (tx_start === 1'b1) begin
                #1 tx_busy = 1'b1;
                repeat (BYTE_CYCLES) @(posedge sys_clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each launched frame must match the oldest expected frame.
    always @(negedge sys_clk) begin
        if (place_ack === 1'b1) place_acks++;
        if (destroy_ack === 1'b1) destroy_acks++;
        if (tx_start === 1'b1) begin
            frames++;
            checkOutput("sb_expected_frame_present", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                checkOutput("sb_tx_data", tx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int start_frames;
        int i;
        rst          = 1'b0;
        power        = 1'b1;
        moving_state = 4'b0001;
        place_req    = 1'b0;
        destroy_req  = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 8'h80);
        checkOutput("rst_place_ack", place_ack, 0);
        checkOutput("rst_destroy_ack", destroy_ack, 0);
        checkOutput("rst_detector", detector, 0);
        checkOutput("rst_link_ok", link_ok, 0);

        $display("[TB] initial drive frame after reset release");
        exp_q.push_back(8'h81);
        rst = 1'b1;
        waitFrames(1);
        settle();

        $display("[TB] quiet period then unprompted refresh");
        repeat (230) @(negedge sys_clk);
        checkOutput("no_early_refresh", frames, 1);
        exp_q.push_back(8'h81);
        waitFrames(2);
        settle();

        $display("[TB] drive change and power fall");
        exp_q.push_back(8'h82);
        moving_state = 4'b0010;
        waitFrames(3);
        settle();
        exp_q.push_back(8'h80);
        power = 1'b0;
        waitFrames(4);
        settle();
        checkOutput("acks_none_yet", place_acks + destroy_acks, 0);

        $display("[TB] simultaneous place and destroy with latency");
        exp_q.push_back(8'hB0);
        applyStimulus(1'b1, 1'b1);
        @(negedge sys_clk);
        checkOutput("lat_k1_tx_start", tx_start, 0);
        @(negedge sys_clk);
        checkOutput("lat_k2_place_ack", place_ack, 1);
        checkOutput("lat_k2_destroy_ack", destroy_ack, 1);
        checkOutput("lat_k2_tx_data", tx_data, 8'hB0);
        @(negedge sys_clk);
        checkOutput("lat_k3_tx_start", tx_start, 1);

        $display("[TB] place request while transmitter busy");
        repeat (3) @(negedge sys_clk);
        checkOutput("busy_during_place", tx_busy, 1);
        exp_q.push_back(8'h90);
        applyStimulus(1'b1, 1'b0);
        start_frames = frames;
        i = 0;
        while (tx_busy === 1'b1 && i < 100) begin
            @(negedge sys_clk);
            i++;
        end
        checkOutput("busy_fell", tx_busy, 0);
        checkOutput("no_launch_while_busy", frames, start_frames);
        waitFrames(6);
        settle();
        checkOutput("place_ack_count", place_acks, 2);
        checkOutput("destroy_ack_count", destroy_acks, 1);

        $display("[TB] detector receive path");
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1 rx_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("rx_detector", detector, 4'b0101);
        checkOutput("rx_link_ok", link_ok, 1);
        repeat (TIMEOUT + 10) @(negedge sys_clk);
`ifdef LINK_WATCHDOG_EN
        checkOutput("timeout_detector", detector, 4'b1111);
        checkOutput("timeout_link_ok", link_ok, 0);
`else
        checkOutput("hold_detector", detector, 4'b0101);
        checkOutput("hold_link_ok", link_ok, 1);
`endif
        rx_data  = 8'hFA;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1 rx_valid = 1'b0;
        @(negedge sys_clk);
        checkOutput("rx2_detector", detector, 4'b1010);
        checkOutput("rx2_link_ok", link_ok, 1);

        $display("[TB] reset asserted during SEND");
        power        = 1'b1;
        moving_state = 4'b0011;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        checkOutput("send_tx_start", tx_start, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_async_tx_start", tx_start, 0);
        checkOutput("rst_mid_tx_data", tx_data, 8'h80);
        checkOutput("rst_mid_state", dut.state, IDLE);
        @(negedge sys_clk);
        checkOutput("rst_mid_detector", detector, 0);
        checkOutput("rst_mid_link_ok", link_ok, 0);
        exp_q.push_back(8'h83);
        rst = 1'b1;
        waitFrames(7);
        settle();
        checkOutput("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
